uart_host_bridge: RTL and testbench
===================================

// Module: uart_host_bridge
// PURPOSE
//   Initiator for the simpleuart register interface (div/dat regs, wait handshake).
//   - Byte-stream side: TX FIFO and RX FIFO with valid/ready handshakes.
//   - UART side: programs the divider, writes TX bytes and honours reg_dat_wait.
//   - Also polls reg_dat_do for received bytes and pops them with reg_dat_re.
//   - Lets stream logic use the UART without knowing its register protocol.
// PARAMETERS
//   DIVIDER     48  divider written at reset exit (250000 baud @ 12 MHz)
//   FIFO_DEPTH  8   entries per FIFO, power of 2, >= 2
// PORTS
//   clk           in   1   single clock, rising edge
//   resetn        in   1   asynchronous, active-low reset
//   tx_valid      in   1   stream byte offered
//   tx_data       in   8   stream byte to transmit
//   tx_ready      out  1   TX FIFO not full
//   rx_valid      out  1   RX FIFO not empty
//   rx_data       out  8   RX FIFO head (show-ahead)
//   rx_ready      in   1   consumer pops head
//   cfg_div_valid in   1   one-cycle request to reprogram the divider
//   cfg_div       in   32  new divider value
//   tx_level      out  L   TX FIFO occupancy, L = $clog2(FIFO_DEPTH)+1
//   rx_level      out  L   RX FIFO occupancy
//   reg_div_we    out  4   divider byte enables to simpleuart
//   reg_div_di    out  32  divider value to simpleuart
//   reg_dat_we    out  1   data write strobe, held until accepted
//   reg_dat_re    out  1   data read strobe, one cycle
//   reg_dat_di    out  32  {24'h0, tx byte}
//   reg_dat_do    in   32  received byte or 32'hFFFF_FFFF when none
//   reg_dat_wait  in   1   write stall from simpleuart
// BEHAVIOUR
//   Reset (async, while resetn low):
//   - All reg_* outputs are 0. Both FIFOs are empty; levels are 0.
//   - tx_ready is 0, rx_valid is 0, FSM is in INIT.
//   - Reset mid-write drops the FIFO contents and the byte in flight.
//   FSM states: INIT, IDLE, WRITE, READ.
//   INIT (one cycle):
//   - reg_div_we=4'hF; reg_div_di=pending divider (DIVIDER after reset). Then go to IDLE.
//   IDLE: the first match wins.
//   - (a) cfg pending -> INIT.
//   - (b) reg_dat_do != 32'hFFFF_FFFF and RX FIFO not full -> READ.
//   - (c) TX FIFO not empty -> WRITE.
//   - RX has priority over TX because the UART buffer holds only one byte.
//   WRITE:
//   - reg_dat_we=1 and reg_dat_di={24'h0,TX head}, held stable.
//   - Accepted on the rising edge where reg_dat_we=1 and reg_dat_wait=0.
//   - That edge pops TX and returns to IDLE. reg_dat_we is 0 on the next cycle,
//     so the UART never sees a double send.
//   READ (one cycle):
//   - reg_dat_re=1. The same edge pushes reg_dat_do[7:0] into RX, then IDLE.
//   - At least one IDLE cycle separates successive strobes.
//   cfg_div_valid:
//   - Latches cfg_div and sets pending. It is applied only from IDLE, never during WRITE.
//   - A later request before INIT overwrites the pending value.
//   RX full with a byte waiting: no read. The UART keeps or overwrites its own buffer.
//   FIFOs:
//   - Pointers wrap modulo FIFO_DEPTH.
//   - tx_ready = !full; a push while full is ignored, even if a pop occurs that cycle.
//   - A pop while empty is ignored. Simultaneous push+pop leaves the level unchanged.
//   - Data appears on rx_data/rx_valid the cycle after the push edge.
// TESTING
//   1 Release reset -> exactly one cycle reg_div_we=4'hF with reg_div_di=32'h30; then 0.
//   2 Push 0x13 while the model holds wait=1 for 50 cycles -> we=1, di=0x13 throughout;
//     exactly one accepted write; tx_level returns to 0.
//   3 Model reg_dat_do=0x13 -> one reg_dat_re pulse; next cycle rx_valid=1, rx_data=0x13.
//     With reg_dat_do=FFFF_FFFF, reg_dat_re stays 0.
//   4 Push 9 bytes 0x00..0x08 with wait=1 -> tx_ready=0 at level 8; all bytes
//     emitted in order once wait releases.
//   5 RX byte 0xA5 pending and TX 0x5A queued together -> READ occurs before WRITE.
//   6 cfg_div_valid with cfg_div=0x60 during WRITE -> divider written only after acceptance.
//   7 Assert resetn=0 mid-WRITE -> all outputs 0 at once; after release, INIT again with 48.

Source files
------------

// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - byte-stream to simpleuart register-interface bridge
// Ports: clk, resetn (async, active-low)
//        tx_valid/tx_data/tx_ready   : byte stream into the TX FIFO
//        rx_valid/rx_data/rx_ready   : show-ahead byte stream out of the RX FIFO
//        cfg_div_valid/cfg_div       : divider reprogram request
//        tx_level/rx_level           : FIFO occupancies
//        reg_div_*, reg_dat_*        : simpleuart register initiator
module uart_host_bridge #(
    parameter int DIVIDER    = 48,
    parameter int FIFO_DEPTH = 8,
    localparam int L         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         tx_valid,
    input  logic [7:0]   tx_data,
    output logic         tx_ready,
    output logic         rx_valid,
    output logic [7:0]   rx_data,
    input  logic         rx_ready,
    input  logic         cfg_div_valid,
    input  logic [31:0]  cfg_div,
    output logic [L-1:0] tx_level,
    output logic [L-1:0] rx_level,
    output logic [3:0]   reg_div_we,
    output logic [31:0]  reg_div_di,
    output logic         reg_dat_we,
    output logic         reg_dat_re,
    output logic [31:0]  reg_dat_di,
    input  logic [31:0]  reg_dat_do,
    input  logic         reg_dat_wait
);
    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam logic [L-1:0] FULL_LVL = L'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_READ} state_t;

    state_t        r_state;
    logic          r_cfg_pending;
    logic [31:0]   r_pending_div;

    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [L-1:0]  r_tx_level;

    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [L-1:0]  r_rx_level;

    logic w_tx_full;
    logic w_tx_empty;
    logic w_tx_push;
    logic w_tx_pop;
    logic w_rx_full;
    logic w_rx_empty;
    logic w_rx_push;
    logic w_rx_pop;
    logic w_rx_avail;

    assign w_tx_full  = (r_tx_level == FULL_LVL);
    assign w_tx_empty = (r_tx_level == '0);
    assign w_rx_full  = (r_rx_level == FULL_LVL);
    assign w_rx_empty = (r_rx_level == '0);

    // Full is judged on the pre-edge level, so a push into a full FIFO is
    // dropped even when the same edge pops an entry.
    assign w_tx_push  = tx_valid && !w_tx_full;
    // The write strobe is high throughout WRITE, so acceptance is just !wait.
    assign w_tx_pop   = (r_state == S_WRITE) && !reg_dat_wait;
    assign w_rx_push  = (r_state == S_READ) && !w_rx_full;
    assign w_rx_pop   = rx_ready && !w_rx_empty;
    assign w_rx_avail = (reg_dat_do != 32'hFFFF_FFFF);

    // Level is 0 while in reset, so gate with resetn to keep tx_ready low there.
    assign tx_ready = resetn && !w_tx_full;
    assign rx_valid = !w_rx_empty;
    assign rx_data  = r_rx_mem[r_rx_rptr];
    assign tx_level = r_tx_level;
    assign rx_level = r_rx_level;

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= tx_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= reg_dat_do[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_level <= r_tx_level + 1'b1;
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_level <= r_tx_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_level <= r_rx_level + 1'b1;
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_level <= r_rx_level - 1'b1;
            end
        end
    end

    // Outputs are registered on the edge that enters a state, so each strobe
    // is visible for exactly the cycles the FSM spends in that state. INIT's
    // divider write therefore shows up during the following IDLE cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_INIT;
            r_cfg_pending <= 1'b0;
            r_pending_div <= 32'(DIVIDER);
            reg_div_we    <= 4'h0;
            reg_div_di    <= 32'h0;
            reg_dat_we    <= 1'b0;
            reg_dat_re    <= 1'b0;
            reg_dat_di    <= 32'h0;
        end else begin
            reg_div_we <= 4'h0;
            reg_dat_re <= 1'b0;
            case (r_state)
                S_INIT: begin
                    reg_div_we    <= 4'hF;
                    reg_div_di    <= r_pending_div;
                    r_cfg_pending <= 1'b0;
                    r_state       <= S_IDLE;
                end
                S_IDLE: begin
                    // RX first: the UART holds only one received byte.
                    if (r_cfg_pending) begin
                        r_state <= S_INIT;
                    end else if (w_rx_avail && !w_rx_full) begin
                        reg_dat_re <= 1'b1;
                        r_state    <= S_READ;
                    end else if (!w_tx_empty) begin
                        reg_dat_we <= 1'b1;
                        reg_dat_di <= {24'h0, r_tx_mem[r_tx_rptr]};
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!reg_dat_wait) begin
                        reg_dat_we <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_READ: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
            // A request arriving on the INIT edge stays pending for the next round.
            if (cfg_div_valid) begin
                r_cfg_pending <= 1'b1;
                r_pending_div <= cfg_div;
            end
        end
    end
endmodule

// File: tb/tb_uart_host_bridge.sv
// tb/tb_uart_host_bridge.sv - self-checking bench for uart_host_bridge
module tb_uart_host_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cfg_div_valid;
    logic [31:0] cfg_div;
    logic [3:0]  tx_level;
    logic [3:0]  rx_level;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    uart_host_bridge #(.DIVIDER(48), .FIFO_DEPTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cfg_div_valid(cfg_div_valid), .cfg_div(cfg_div),
        .tx_level(tx_level), .rx_level(rx_level),
        .reg_div_we(reg_div_we), .reg_div_di(reg_div_di),
        .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
        .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [7:0]  sent[$];
    logic [7:0]  events[$];
    logic [31:0] exp_div = 32'd48;
    int          div_pulses = 0;
    int          acc_cnt = 0;
    int          re_cnt = 0;
    int          cyc = 0;
    int          last_div_cyc = 0;
    int          last_acc_cyc = 0;
    logic [31:0] last_div_val = 32'h0;
    logic        prev_held = 1'b0;
    logic        prev_gap = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_di = 32'h0;
    logic        consume = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model of the bridge, evaluated mid-cycle; it checks the
    // current outputs, then advances across the coming rising edge.
    task automatic model_cycle();
        int   strobes;
        logic push_tx;
        logic pop_rx;
        cyc++;
        if (!resetn) begin
            check("rst_div_we", 32'(reg_div_we), 32'h0);
            check("rst_div_di", reg_div_di, 32'h0);
            check("rst_dat_we", 32'(reg_dat_we), 32'h0);
            check("rst_dat_re", 32'(reg_dat_re), 32'h0);
            check("rst_dat_di", reg_dat_di, 32'h0);
            check("rst_tx_ready", 32'(tx_ready), 32'h0);
            check("rst_rx_valid", 32'(rx_valid), 32'h0);
            check("rst_tx_level", 32'(tx_level), 32'h0);
            check("rst_rx_level", 32'(rx_level), 32'h0);
            txq.delete();
            rxq.delete();
            exp_div   = 32'd48;
            prev_held = 1'b0;
            prev_gap  = 1'b0;
            prev_we   = 1'b0;
            consume   = 1'b0;
            return;
        end
        check("tx_level", 32'(tx_level), 32'(txq.size()));
        check("rx_level", 32'(rx_level), 32'(rxq.size()));
        check("tx_ready", 32'(tx_ready), 32'(txq.size() < 8));
        check("rx_valid", 32'(rx_valid), 32'(rxq.size() > 0));
        if (rxq.size() > 0) check("rx_data", 32'(rx_data), 32'(rxq[0]));
        strobes = int'(reg_div_we != 4'h0) + int'(reg_dat_we) + int'(reg_dat_re);
        check("single_strobe", 32'(strobes <= 1), 32'h1);
        if (reg_div_we != 4'h0) begin
            check("div_we_all", 32'(reg_div_we), 32'hF);
            check("div_di", reg_div_di, exp_div);
            div_pulses++;
            last_div_cyc = cyc;
            last_div_val = reg_div_di;
        end
        if (reg_dat_we) begin
            if (txq.size() == 0) check("dat_we_with_empty_fifo", 32'(reg_dat_we), 32'h0);
            else check("dat_di", reg_dat_di, {24'h0, txq[0]});
        end
        if (prev_held) begin
            check("we_held", 32'(reg_dat_we), 32'h1);
            check("di_held", reg_dat_di, prev_di);
        end
        if (prev_gap) check("gap_after_strobe", 32'(strobes), 32'h0);
        if (reg_dat_re) check("re_with_byte", 32'(reg_dat_do != 32'hFFFF_FFFF), 32'h1);
        if (reg_dat_re) events.push_back("R");
        if (reg_dat_we && !prev_we) events.push_back("W");

        push_tx = tx_valid && (txq.size() < 8);
        pop_rx  = rx_ready && (rxq.size() > 0);
        if (reg_dat_we && !reg_dat_wait && txq.size() > 0) begin
            sent.push_back(txq.pop_front());
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (push_tx) txq.push_back(tx_data);
        if (pop_rx) rxq.delete(0);
        if (reg_dat_re) begin
            rxq.push_back(reg_dat_do[7:0]);
            re_cnt++;
        end
        if (cfg_div_valid) exp_div = cfg_div;
        prev_held = reg_dat_we && reg_dat_wait;
        prev_gap  = reg_dat_re || (reg_dat_we && !reg_dat_wait);
        prev_we   = reg_dat_we;
        prev_di   = reg_dat_di;
        consume   = reg_dat_re;
    endtask

    // One clock: model/compare mid-cycle, then drive just after the rising edge.
    // The UART's receive register empties after a read strobe.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        if (consume) begin
            reg_dat_do = 32'hFFFF_FFFF;
            consume    = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic ok;
        ok       = 1'b0;
        tx_valid = 1'b1;
        tx_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = tx_ready;
            tick();
        end
        tx_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'h1);
    endtask

    task automatic wait_sent(input int n);
        for (int i = 0; i < 300 && sent.size() < n; i++) tick();
        check("sent_count", 32'(sent.size()), 32'(n));
    endtask

    initial begin
        int d0;
        int a0;
        int r0;
        resetn        = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h0;
        rx_ready      = 1'b0;
        cfg_div_valid = 1'b0;
        cfg_div       = 32'h0;
        reg_dat_do    = 32'hFFFF_FFFF;
        reg_dat_wait  = 1'b0;

        // 1: reset exit writes the default divider exactly once
        ticks(3);
        check("t1_rst_tx_ready", 32'(tx_ready), 32'h0);
        check("t1_rst_div_we", 32'(reg_div_we), 32'h0);
        resetn = 1'b1;
        d0 = div_pulses;
        tick();
        check("t1_div_we", 32'(reg_div_we), 32'hF);
        check("t1_div_di", reg_div_di, 32'h30);
        tick();
        check("t1_div_we_off", 32'(reg_div_we), 32'h0);
        ticks(5);
        check("t1_div_pulses", 32'(div_pulses - d0), 32'h1);
        check("t1_tx_ready", 32'(tx_ready), 32'h1);

        // 2: write held through 50 cycles of wait
        reg_dat_wait = 1'b1;
        sent.delete();
        push_byte(8'h13);
        ticks(50);
        check("t2_we_held", 32'(reg_dat_we), 32'h1);
        check("t2_di_held", reg_dat_di, 32'h13);
        check("t2_level_held", 32'(tx_level), 32'h1);
        reg_dat_wait = 1'b0;
        wait_sent(1);
        ticks(5);
        check("t2_one_write", 32'(acc_cnt), 32'h1);
        check("t2_byte", 32'(sent[0]), 32'h13);
        check("t2_level", 32'(tx_level), 32'h0);

        // 3: one read strobe per received byte
        r0 = re_cnt;
        reg_dat_do = 32'h13;
        tick();
        check("t3_re", 32'(reg_dat_re), 32'h1);
        tick();
        check("t3_re_off", 32'(reg_dat_re), 32'h0);
        check("t3_rx_valid", 32'(rx_valid), 32'h1);
        check("t3_rx_data", 32'(rx_data), 32'h13);
        ticks(20);
        check("t3_one_read", 32'(re_cnt - r0), 32'h1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t3_rx_empty", 32'(rx_level), 32'h0);

        // 4: fill TX to 8 while stalled, ninth byte waits for room, all emitted in order
        reg_dat_wait = 1'b1;
        sent.delete();
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        check("t4_level_full", 32'(tx_level), 32'h8);
        check("t4_ready_low", 32'(tx_ready), 32'h0);
        tx_valid = 1'b1;
        tx_data  = 8'h08;
        ticks(3);
        check("t4_level_still_full", 32'(tx_level), 32'h8);
        reg_dat_wait = 1'b0;
        push_byte(8'h08);
        wait_sent(9);
        for (int i = 0; i < 9 && i < sent.size(); i++) check("t4_order", 32'(sent[i]), 32'(i));
        ticks(3);
        check("t4_level_empty", 32'(tx_level), 32'h0);

        // 5: RX byte and TX byte both pending -> read first
        reg_dat_wait = 1'b1;
        sent.delete();
        push_byte(8'h11);
        ticks(3);
        events.delete();
        push_byte(8'h5A);
        reg_dat_do = 32'hA5;
        ticks(2);
        reg_dat_wait = 1'b0;
        wait_sent(2);
        ticks(3);
        check("t5_event_count", 32'(events.size()), 32'h2);
        if (events.size() >= 2) begin
            check("t5_first_read", 32'(events[0]), 32'h52);
            check("t5_then_write", 32'(events[1]), 32'h57);
        end
        check("t5_sent_second", 32'(sent.size() >= 2 ? sent[1] : 8'h0), 32'h5A);
        check("t5_rx_data", 32'(rx_data), 32'hA5);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;

        // 6: divider request during WRITE is deferred until acceptance
        reg_dat_wait = 1'b1;
        push_byte(8'h77);
        ticks(3);
        d0 = div_pulses;
        a0 = acc_cnt;
        cfg_div       = 32'h60;
        cfg_div_valid = 1'b1;
        tick();
        cfg_div_valid = 1'b0;
        ticks(20);
        check("t6_no_div_in_write", 32'(div_pulses - d0), 32'h0);
        reg_dat_wait = 1'b0;
        ticks(10);
        check("t6_accepted", 32'(acc_cnt - a0), 32'h1);
        check("t6_div_written", 32'(div_pulses - d0), 32'h1);
        check("t6_div_after_accept", 32'(last_div_cyc > last_acc_cyc), 32'h1);
        check("t6_div_value", last_div_val, 32'h60);

        // 7: reset mid-write drops everything and re-runs INIT with 48
        reg_dat_wait = 1'b1;
        push_byte(8'h99);
        ticks(3);
        check("t7_in_write", 32'(reg_dat_we), 32'h1);
        check("t7_in_write_di", reg_dat_di, 32'h99);
        resetn = 1'b0;
        #1;
        check("t7_we_cleared", 32'(reg_dat_we), 32'h0);
        check("t7_di_cleared", reg_dat_di, 32'h0);
        check("t7_level_cleared", 32'(tx_level), 32'h0);
        check("t7_ready_low", 32'(tx_ready), 32'h0);
        ticks(2);
        reg_dat_wait = 1'b0;
        a0 = acc_cnt;
        resetn = 1'b1;
        tick();
        check("t7_div_we", 32'(reg_div_we), 32'hF);
        check("t7_div_di", reg_div_di, 32'h30);
        ticks(10);
        check("t7_no_write", 32'(acc_cnt - a0), 32'h0);
        check("t7_level", 32'(tx_level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
